// File: rtl/ser_8b10b_pkg.sv
// Shared definitions for the 8b/10b serial transmit path: symbol width, K28.5 idle
// codes for both disparities, the symbol-source enum and a popcount helper.
package ser_8b10b_pkg;

    localparam int unsigned SYM_W = 10;

    // K28.5 in abcdei_fghj order, bit 9 = 'a'
    localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
    localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

    typedef enum logic {
        SrcData,
        SrcIdle
    } src_e;

    function automatic logic [3:0] popcount10(input logic [SYM_W-1:0] sym);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < SYM_W; i++) begin
            cnt = cnt + {3'd0, sym[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sym_disp_calc.sv
// Combinational disparity evaluation of one 10-bit symbol against the current running
// disparity; shared by the transmitter and the receive-side checker.
module sym_disp_calc
    import ser_8b10b_pkg::*;
(
    input  logic [SYM_W-1:0] sym_i,
    input  logic             rd_i,
    output logic [3:0]       ones_o,
    output logic             next_rd_o,
    output logic             err_o
);

    always_comb begin
        ones_o = popcount10(sym_i);

        if (ones_o > 4'd5) begin
            next_rd_o = 1'b1;
        end else if (ones_o < 4'd5) begin
            next_rd_o = 1'b0;
        end else begin
            next_rd_o = rd_i;
        end

        // Legal symbols are balanced or off by one, and must pull RD back toward zero
        err_o = (ones_o < 4'd4) || (ones_o > 4'd6)
             || ((ones_o == 4'd6) && rd_i)
             || ((ones_o == 4'd4) && !rd_i);
    end

endmodule

// File: rtl/ser_10b_tx.sv
// 10-bit symbol serializer with running-disparity tracking and K28.5 idle insertion.
// Define SER_DISP_CHECK_EN to enable the disparity error pulse on disp_err.
module ser_10b_tx
    import ser_8b10b_pkg::*;
#(
    parameter logic [SYM_W-1:0] IDLE_RDN = K28_5_RDN,
    parameter logic [SYM_W-1:0] IDLE_RDP = K28_5_RDP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             rd_out,
    output logic             ser_out,
    output logic             sym_start,
    output logic             idle_active,
    output logic             disp_err
);

    logic [SYM_W-1:0] shift_q, shift_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic             rd_q, rd_d;
    src_e             src_q, src_d;
    logic             ser_q;
    logic             start_q, start_d;
    logic             idle_q;
    logic             derr_q, derr_d;

    logic             load;
    logic [SYM_W-1:0] ld_sym;
    logic [3:0]       unused_ones;
    logic             calc_rd;
    logic             calc_err;

    assign load      = (bit_cnt_q == 4'd9);
    assign sym_ready = load;

    // Idle polarity follows the RD before this load's update
    assign ld_sym = sym_valid ? sym_in : (rd_q ? IDLE_RDP : IDLE_RDN);

    sym_disp_calc u_disp_calc (
        .sym_i     (ld_sym),
        .rd_i      (rd_q),
        .ones_o    (unused_ones),
        .next_rd_o (calc_rd),
        .err_o     (calc_err)
    );

    always_comb begin
        shift_d   = {shift_q[SYM_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 4'd1;
        rd_d      = rd_q;
        src_d     = src_q;
        start_d   = 1'b0;
        derr_d    = 1'b0;
        if (load) begin
            shift_d   = ld_sym;
            bit_cnt_d = 4'd0;
            rd_d      = calc_rd;
            src_d     = sym_valid ? SrcData : SrcIdle;
            start_d   = 1'b1;
`ifdef SER_DISP_CHECK_EN
            derr_d    = sym_valid & calc_err;
`endif
        end
    end

`ifndef SER_DISP_CHECK_EN
    logic unused_err;
    assign unused_err = calc_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= 4'd9;
            rd_q      <= 1'b0;
            src_q     <= SrcData;
            ser_q     <= 1'b0;
            start_q   <= 1'b0;
            idle_q    <= 1'b0;
            derr_q    <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rd_q      <= rd_d;
            src_q     <= src_d;
            // Register the next MSB so bit 'a' is on the line the cycle after the load
            ser_q     <= shift_d[SYM_W-1];
            start_q   <= start_d;
            idle_q    <= (src_d == SrcIdle);
            derr_q    <= derr_d;
        end
    end

    assign rd_out      = rd_q;
    assign ser_out     = ser_q;
    assign sym_start   = start_q;
    assign idle_active = idle_q;
    assign disp_err    = derr_q;

endmodule
